// File: rtl/prewitt_pkg.sv
// rtl/prewitt_pkg.sv - shared widths, tap indices and FSM states for the 3x3 window generator
package prewitt_pkg;
  localparam int ROWS_DEF   = 242;
  localparam int COLS_DEF   = 247;
  localparam int DATA_W_DEF = 8;
  localparam int ROW_W      = $clog2(ROWS_DEF);
  localparam int COL_W      = $clog2(COLS_DEF);
  localparam int WIN_W      = 9 * DATA_W_DEF;

  localparam int TL = 0;
  localparam int TC = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MC = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BC = 7;
  localparam int BR = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/pw_line_delay.sv
// rtl/pw_line_delay.sv - enabled DEPTH-stage shift delay; dout is the sample shifted in DEPTH steps ago
module pw_line_delay #(
  parameter int DEPTH  = 247,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];
endmodule

// File: rtl/prewitt_window_gen.sv
// rtl/prewitt_window_gen.sv - streaming 3x3 neighbourhood generator with zero-filled borders
module prewitt_window_gen
  import prewitt_pkg::*;
#(
  parameter int ROWS   = 242,
  parameter int COLS   = 247,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_pixel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [9*DATA_W-1:0]       out_win,
  output logic                      out_border,
  output logic [$clog2(ROWS)-1:0]   out_row,
  output logic [$clog2(COLS)-1:0]   out_col,
  output logic                      frame_done
);
  localparam int RB = $clog2(ROWS);
  localparam int CB = $clog2(COLS);
  localparam logic [RB-1:0] LAST_ROW = RB'(ROWS - 1);
  localparam logic [CB-1:0] LAST_COL = CB'(COLS - 1);

  state_e state_q, state_d;
  logic [RB-1:0] in_row_q, in_row_d, ctr_row_q, ctr_row_d;
  logic [CB-1:0] in_col_q, in_col_d, ctr_col_q, ctr_col_d;
  logic [DATA_W-1:0] tap_q [9];
  logic [DATA_W-1:0] tap_d [9];
  logic [DATA_W-1:0] ld1_out, ld2_out, col_in;
  logic [9*DATA_W-1:0] win_d, out_win_q;
  logic border_d, out_border_q, out_valid_q, out_valid_d;
  logic [RB-1:0] out_row_q;
  logic [CB-1:0] out_col_q;
  logic in_fire, out_fire, out_is_last, flush_step, step, load;

  assign in_ready = !rst && ((state_q == FILL) ||
                             (state_q == RUN && (!out_valid_q || out_ready)));
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid_q && out_ready;
  assign out_is_last = (out_row_q == LAST_ROW) && (out_col_q == LAST_COL);
  // Flush stops issuing once the final window is parked on the output.
  assign flush_step  = (state_q == FLUSH) && (!out_valid_q || out_ready) &&
                       !(out_valid_q && out_is_last);
  assign step   = in_fire || flush_step;
  assign load   = (in_fire && state_q == RUN) || flush_step;
  assign col_in = in_fire ? in_pixel : '0;

  pw_line_delay #(.DEPTH(COLS), .DATA_W(DATA_W)) u_ld1 (
    .clk(clk), .en_i(step), .din_i(col_in), .dout_o(ld1_out)
  );
  pw_line_delay #(.DEPTH(COLS), .DATA_W(DATA_W)) u_ld2 (
    .clk(clk), .en_i(step), .din_i(ld1_out), .dout_o(ld2_out)
  );

  always_comb begin
    tap_d = tap_q;
    if (step) begin
      for (int r = 0; r < 3; r++) begin
        tap_d[3*r]   = tap_q[3*r+1];
        tap_d[3*r+1] = tap_q[3*r+2];
      end
      tap_d[TR] = ld2_out;
      tap_d[MR] = ld1_out;
      tap_d[BR] = col_in;
    end
  end

  // Taps are masked by the centre position so wrapped or stale pixels never leak.
  always_comb begin
    win_d = '0;
    for (int k = 0; k < 9; k++) begin
      if (!((k < 3 && ctr_row_q == '0) || (k >= 6 && ctr_row_q == LAST_ROW) ||
            (k % 3 == 0 && ctr_col_q == '0) || (k % 3 == 2 && ctr_col_q == LAST_COL))) begin
        win_d[k*DATA_W +: DATA_W] = tap_d[k];
      end
    end
    border_d = (ctr_row_q == '0) || (ctr_row_q == LAST_ROW) ||
               (ctr_col_q == '0) || (ctr_col_q == LAST_COL);
  end

  always_comb begin
    in_row_d = in_row_q;
    in_col_d = in_col_q;
    if (in_fire) begin
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
    ctr_row_d = ctr_row_q;
    ctr_col_d = ctr_col_q;
    if (load) begin
      if (ctr_col_q == LAST_COL) begin
        ctr_col_d = '0;
        ctr_row_d = (ctr_row_q == LAST_ROW) ? '0 : ctr_row_q + 1'b1;
      end else begin
        ctr_col_d = ctr_col_q + 1'b1;
      end
    end
    out_valid_d = load ? 1'b1 : (out_fire ? 1'b0 : out_valid_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:  if (in_fire && in_row_q == RB'(1) && in_col_q == '0) state_d = RUN;
      RUN:   if (in_fire && in_row_q == LAST_ROW && in_col_q == LAST_COL) state_d = FLUSH;
      FLUSH: if (out_fire && out_is_last) state_d = DONE;
      DONE:  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      in_row_q     <= '0;
      in_col_q     <= '0;
      ctr_row_q    <= '0;
      ctr_col_q    <= '0;
      out_valid_q  <= 1'b0;
      out_win_q    <= '0;
      out_border_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      for (int k = 0; k < 9; k++) tap_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      in_row_q    <= in_row_d;
      in_col_q    <= in_col_d;
      ctr_row_q   <= ctr_row_d;
      ctr_col_q   <= ctr_col_d;
      out_valid_q <= out_valid_d;
      tap_q       <= tap_d;
      if (load) begin
        out_win_q    <= win_d;
        out_border_q <= border_d;
        out_row_q    <= ctr_row_q;
        out_col_q    <= ctr_col_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_win    = out_win_q;
  assign out_border = out_border_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = (state_q == DONE);
endmodule

// File: tb/tb_prewitt_window_gen.sv
// tb/tb_prewitt_window_gen.sv - scoreboard and vector-table bench for prewitt_window_gen (4x5 frame)
module tb_prewitt_window_gen;
  localparam int R  = 4;
  localparam int C  = 5;
  localparam int W  = 8;
  localparam int NW = R * C;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_border, frame_done;
  logic [W-1:0] in_pixel;
  logic [9*W-1:0] out_win;
  logic [1:0] out_row;
  logic [2:0] out_col;

  always #5 clk = ~clk;

  prewitt_window_gen #(.ROWS(R), .COLS(C), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win), .out_border(out_border),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  typedef struct {
    int         n;
    logic [71:0] win;
    logic       border;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[4];
  vec_t e;
  int errors = 0, checks = 0;
  int win_cnt = 0, done_cnt = 0, fidx = 0;
  logic [71:0] cap [3][NW];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic vec_t model(input int n);
    vec_t v;
    int r, c, sr, sc;
    r = n / C;
    c = n % C;
    v.n = n;
    v.win = '0;
    v.border = (r == 0 || r == R-1 || c == 0 || c == C-1);
    for (int k = 0; k < 9; k++) begin
      sr = r + k / 3 - 1;
      sc = c + k % 3 - 1;
      if (sr >= 0 && sr < R && sc >= 0 && sc < C) v.win[k*8 +: 8] = 8'(sr * C + sc);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got row %0d col %0d expected no window", out_row, out_col);
        end else begin
          e = sb_q.pop_front();
          check("win", out_win, e.win);
          check("border", 72'(out_border), 72'(e.border));
          check("pos", 72'({out_row, out_col}), 72'({2'(e.n / C), 3'(e.n % C)}));
          for (int i = 0; i < 4; i++) begin
            if (tbl[i].n == e.n) begin
              check("table_win", out_win, tbl[i].win);
              check("table_border", 72'(out_border), 72'(tbl[i].border));
            end
          end
          cap[fidx][e.n] = out_win;
          win_cnt++;
        end
      end
    end
  end

  task automatic send_pixels(input int last_pix);
    logic acc;
    int tries;
    for (int m = 0; m <= last_pix; m++) begin
      in_valid = 1'b1;
      in_pixel = 8'(m);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        tries++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for pixel %0d expected 1", m);
      end
      if (m <= C) check("fill_no_output", 72'(out_valid), 72'(0));
      else begin
        sb_q.push_back(model(m - C - 1));
        if (m == C + 1) check("first_window_valid", 72'(out_valid), 72'(1));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame();
    logic got;
    for (int n = NW - C - 1; n < NW; n++) sb_q.push_back(model(n));
    in_valid = 1'b1;
    in_pixel = 8'hAA;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
      else begin
        check("flush_in_ready", 72'(in_ready), 72'(0));
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse expected one");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int f);
    int w0, d0;
    fidx = f;
    w0 = win_cnt;
    d0 = done_cnt;
    send_pixels(NW - 1);
    finish_frame();
    check("window_count", 72'(win_cnt - w0), 72'(NW));
    check("done_pulses", 72'(done_cnt - d0), 72'(1));
    check("scoreboard_empty", 72'(sb_q.size()), 72'(0));
  endtask

  task automatic backpressure();
    logic got;
    logic [71:0] held;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_row == 2'd2 && out_col == 3'd2) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bp_window_timeout: got no window (2,2) expected one");
    end else begin
      out_ready = 1'b0;
      held = out_win;
      repeat (3) begin
        @(negedge clk);
        check("bp_in_ready", 72'(in_ready), 72'(0));
        check("bp_valid", 72'(out_valid), 72'(1));
        check("bp_hold", out_win, held);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
    end
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_out_win", out_win, 72'(0));
    check("rst_out_border", 72'(out_border), 72'(0));
    check("rst_out_pos", 72'({out_row, out_col}), 72'(0));
    check("rst_frame_done", 72'(frame_done), 72'(0));
    check("rst_in_ready", 72'(in_ready), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0,  pack9(0, 0, 0, 0, 0, 1, 0, 5, 6), 1'b1};
    tbl[1] = '{6,  pack9(0, 1, 2, 5, 6, 7, 10, 11, 12), 1'b0};
    tbl[2] = '{9,  pack9(3, 4, 0, 8, 9, 0, 13, 14, 0), 1'b1};
    tbl[3] = '{19, pack9(13, 14, 0, 18, 19, 0, 0, 0, 0), 1'b1};
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    fork
      run_frame(0);
      backpressure();
    join

    fidx = 1;
    send_pixels(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    sb_q.delete();
    rst = 1'b0;

    run_frame(1);
    run_frame(2);
    for (int n = 0; n < NW; n++) check("b2b_identical", cap[2][n], cap[1][n]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
